// File: rtl/ila_capture_readout.sv
// Debug capture buffer: masked-compare trigger, DEPTH-sample window around it, streamed out on valid/ready.
// Optional feature macro: ILA_TIMESTAMP_EN (stores a free-running timestamp alongside each sample).
module ila_capture_readout #(
    parameter int PROBE_W = 32,
    parameter int DEPTH   = 256,
    parameter int TS_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PROBE_W-1:0]         probe_in,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [PROBE_W-1:0]         trig_mask,
    input  logic [PROBE_W-1:0]         trig_value,
    input  logic [$clog2(DEPTH)-1:0]   pre_trig,
`ifdef ILA_TIMESTAMP_EN
    output logic [TS_W+PROBE_W-1:0]    rd_data,
`else
    output logic [PROBE_W-1:0]         rd_data,
`endif
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       rd_last,
    output logic                       triggered,
    output logic [2:0]                 state_o
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
`ifdef ILA_TIMESTAMP_EN
    localparam int DW = TS_W + PROBE_W;
`else
    // TS_W stays referenced so both builds share one parameter set.
    localparam int DW = PROBE_W + 0 * TS_W;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_READOUT   = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   p_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   trig_addr_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [CNT_W-1:0]    issue_cnt_q;
    logic                s1_v_q;
    logic                s1_last_q;
    logic [DW-1:0]       ram_q;
    logic [DW-1:0]       rd_data_q;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic                triggered_q;
    logic [DW-1:0]       mem [DEPTH];

    logic                match;
    logic [ADDR_W-1:0]   post_len;
    logic                wr_en;
    logic                rd_en;
    logic                advance;
    logic [DW-1:0]       wr_word;

    assign match    = ((probe_in ^ trig_value) & trig_mask) == '0;
    assign post_len = ADDR_W'(DEPTH - 1) - p_q;
    assign wr_en    = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);

    // Handshake: a word moves when rd_valid & rd_ready at a rising edge; while rd_valid is
    // high and rd_ready low, rd_data/rd_valid/rd_last hold. advance = output slot free next cycle.
    assign advance = !rd_valid_q || rd_ready;
    assign rd_en   = (state_q == S_READOUT) && (issue_cnt_q != CNT_W'(DEPTH)) && (!s1_v_q || advance);

`ifdef ILA_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + TS_W'(1);
    end

    assign wr_word = {ts_q, probe_in};
`else
    assign wr_word = probe_in;
`endif

    // Simple dual-port buffer with registered read; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_word;
        if (rd_en) ram_q <= mem[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        p_q      <= pre_trig;
                        wr_ptr_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= (pre_trig == '0) ? S_WAIT_TRIG : S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    cnt_q    <= cnt_q + ADDR_W'(1);
                    if (cnt_q == p_q - ADDR_W'(1)) state_q <= S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    if (match) begin
                        trig_addr_q <= wr_ptr_q;
                        triggered_q <= 1'b1;
                        cnt_q       <= '0;
                        if (post_len == '0) begin
                            state_q     <= S_READOUT;
                            rd_addr_q   <= wr_ptr_q - p_q;
                            issue_cnt_q <= '0;
                        end else begin
                            state_q <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    cnt_q    <= cnt_q + ADDR_W'(1);
                    if (cnt_q == post_len - ADDR_W'(1)) begin
                        state_q     <= S_READOUT;
                        rd_addr_q   <= trig_addr_q - p_q;
                        issue_cnt_q <= '0;
                    end
                end
                S_READOUT: begin
                    if (rd_en) begin
                        rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                        s1_v_q      <= 1'b1;
                        s1_last_q   <= (issue_cnt_q == CNT_W'(DEPTH - 1));
                    end else if (advance) begin
                        s1_v_q <= 1'b0;
                    end
                    if (advance) begin
                        rd_valid_q <= s1_v_q;
                        rd_last_q  <= s1_v_q && s1_last_q;
                        if (s1_v_q) rd_data_q <= ram_q;
                    end
                    if (rd_valid_q && rd_ready && rd_last_q) begin
                        state_q     <= S_IDLE;
                        s1_v_q      <= 1'b0;
                        rd_data_q   <= '0;
                        rd_valid_q  <= 1'b0;
                        rd_last_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign triggered = triggered_q;
    assign state_o   = state_q;
endmodule
